// File: rtl/axis_video_sink.sv
// AXI4-Stream to VGA-style raster sink.
// Buffers {tuser,tlast,tdata} in a show-ahead FIFO, free-runs the raster
// timing counters and aligns the incoming stream to frame start.
// Optional feature macro: AXIS_VIDEO_SINK_ERR_CNT_EN adds a saturating
// 16-bit err_count output that counts sync_err pulses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_SEARCH | not aligned; drop non-SOF beats, hold SOF beat until (0,0)
// ST_LOCKED | aligned; pop one beat per active pixel, check SOF/EOL framing
module axis_video_sink #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] tdata,
  input  logic        tvalid,
  input  logic        tuser,
  input  logic        tlast,
  output logic        tready,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err
`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        w_h_wrap, w_v_wrap;
  logic        w_active, w_origin, w_line_end;

  logic [25:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_tready;
  logic          w_push, w_pop, w_empty;
  logic [25:0]   w_head;
  logic          w_show, w_err, w_uflow;

  logic        r_video_on, r_hsync, r_vsync, r_sync_err, r_underflow;
  logic [9:0]  r_pixel_x, r_pixel_y;
  logic [11:0] r_rgb;
  logic        w_unused_bits;

  assign w_h_wrap   = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_wrap   = (r_v_cnt == 10'(V_TOTAL - 1));
  assign w_active   = (r_h_cnt < 10'(H_RES)) && (r_v_cnt < 10'(V_RES));
  assign w_origin   = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign w_line_end = (r_h_cnt == 10'(H_RES - 1));

  // Free-running raster counters; the line counter steps on pixel wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_wrap) r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  // tready is registered from the next occupancy so it never sees tvalid
  // combinationally and stays low for the whole cycle the FIFO is full.
  assign w_push      = tvalid && r_tready;
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {tuser, tlast, tdata};
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      r_tready <= (w_count_nxt != (AW+1)'(FIFO_DEPTH));
    end
  end

  // Alignment state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SEARCH;
    else        r_state <= w_state_nxt;
  end

  // Next state, pop and framing checks.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_show      = 1'b0;
    w_err       = 1'b0;
    w_uflow     = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (!w_empty) begin
          if (!w_head[25]) begin
            w_pop = 1'b1;
          end else if (w_origin) begin
            w_pop       = 1'b1;
            w_show      = 1'b1;
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_active) begin
          if (w_empty) begin
            w_err       = 1'b1;
            w_uflow     = 1'b1;
            w_state_nxt = ST_SEARCH;
          end else begin
            w_pop  = 1'b1;
            w_show = 1'b1;
            if ((w_head[25] && !w_origin) || (w_head[24] != w_line_end)) begin
              w_err       = 1'b1;
              w_state_nxt = ST_SEARCH;
            end
          end
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_video_on  <= 1'b0;
      r_pixel_x   <= '0;
      r_pixel_y   <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_rgb       <= '0;
      r_sync_err  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_video_on  <= w_active;
      r_pixel_x   <= w_active ? r_h_cnt : 10'd0;
      r_pixel_y   <= w_active ? r_v_cnt : 10'd0;
      r_hsync     <= !((r_h_cnt >= 10'(H_RES + H_FP)) && (r_h_cnt < 10'(H_RES + H_FP + H_SYNC)));
      r_vsync     <= !((r_v_cnt >= 10'(V_RES + V_FP)) && (r_v_cnt < 10'(V_RES + V_FP + V_SYNC)));
      r_rgb       <= w_show ? {w_head[23:20], w_head[15:12], w_head[7:4]} : 12'd0;
      r_sync_err  <= w_err;
      r_underflow <= r_underflow | w_uflow;
    end
  end

  assign w_unused_bits = ^{w_head[19:16], w_head[11:8], w_head[3:0]};

  assign tready    = r_tready;
  assign video_on  = r_video_on;
  assign pixel_x   = r_pixel_x;
  assign pixel_y   = r_pixel_y;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign rgb_out   = r_rgb;
  assign locked    = (r_state == ST_LOCKED);
  assign underflow = r_underflow;
  assign sync_err  = r_sync_err;

`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Saturating count of framing errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               r_err_count <= '0;
    else if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_axis_video_sink.sv
// Scoreboard bench for axis_video_sink using a reduced raster so several
// frames fit in a short run. Expected outputs come from a queue-based model
// that derives raster position from the cycle count since reset.
module tb_axis_video_sink;

  localparam int HR = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VR = 8,  VFP = 1, VS = 2, VBP = 1;
  localparam int DEPTH = 8;
  localparam int HT = HR + HFP + HS + HBP;
  localparam int VT = VR + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] data;
  } beat_t;

  typedef struct packed {
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        locked;
    logic        serr;
    logic        uf;
    logic        tready;
    logic [15:0] ecnt;
  } exp_t;

  logic        clk, rst_n;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast;
  logic        tready, video_on, hsync, vsync, locked, underflow, sync_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb_out;
`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  axis_video_sink #(
    .H_RES(HR), .V_RES(VR), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rst_n), .tdata(tdata), .tvalid(tvalid), .tuser(tuser),
    .tlast(tlast), .tready(tready), .video_on(video_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out),
    .locked(locked), .underflow(underflow), .sync_err(sync_err)
`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0, n_err = 0;
  int    n_serr_seen, saw_low;
  beat_t src_q[$];
  beat_t m_fifo[$];
  exp_t  exp_q[$];
  int    cyc, m_ecnt;
  bit    m_locked, m_uf;
  int    valid_pct, stall_lo, stall_hi;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_frame(input bit fixed, input int err_line, input int err_col, input bit rnd_err);
    beat_t b;
    for (int y = 0; y < VR; y++) begin
      for (int x = 0; x < HR; x++) begin
        b.user = (x == 0 && y == 0);
        b.last = (x == HR - 1);
        b.data = fixed ? 24'hF0A05A : 24'($urandom);
        if (y == err_line && x == err_col) b.last = 1'b1;
        if (rnd_err) begin
          if ($urandom_range(0, 149) == 0) b.last = ~b.last;
          if ($urandom_range(0, 299) == 0) b.user = 1'b1;
        end
        src_q.push_back(b);
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and predict the
  // outputs the DUT will present after the following rising edge.
  task automatic cycle_body();
    bit    v, acc, act, org, show, serr, pop;
    int    h, ln;
    beat_t hd;
    exp_t  e;
    v = (src_q.size() > 0) && ($urandom_range(1, 100) <= valid_pct)
        && !(cyc >= stall_lo && cyc < stall_hi);
    tvalid = v;
    if (v) begin
      tdata = src_q[0].data;
      tuser = src_q[0].user;
      tlast = src_q[0].last;
    end else begin
      tdata = 24'($urandom);
      tuser = 1'b0;
      tlast = 1'b0;
    end
    acc = v && tready;

    h    = cyc % HT;
    ln   = (cyc / HT) % VT;
    act  = (h < HR) && (ln < VR);
    org  = (h == 0) && (ln == 0);
    show = 0; serr = 0; pop = 0;
    hd   = '0;
    if (!m_locked) begin
      if (m_fifo.size() > 0) begin
        hd = m_fifo[0];
        if (!hd.user) pop = 1;
        else if (org) begin pop = 1; show = 1; m_locked = 1; end
      end
    end else if (act) begin
      if (m_fifo.size() == 0) begin
        serr = 1; m_uf = 1; m_locked = 0;
      end else begin
        hd = m_fifo[0]; pop = 1; show = 1;
        if ((hd.user && !org) || (hd.last != (h == HR - 1))) begin
          serr = 1; m_locked = 0;
        end
      end
    end
    if (serr && m_ecnt < 65535) m_ecnt++;
    if (pop) void'(m_fifo.pop_front());
    if (acc) m_fifo.push_back(src_q.pop_front());

    e.video_on = act;
    e.x        = act ? 10'(h) : 10'd0;
    e.y        = act ? 10'(ln) : 10'd0;
    e.hs       = !(h >= HR + HFP && h < HR + HFP + HS);
    e.vs       = !(ln >= VR + VFP && ln < VR + VFP + VS);
    e.rgb      = show ? {hd.data[23:20], hd.data[15:12], hd.data[7:4]} : 12'd0;
    e.locked   = m_locked;
    e.serr     = serr;
    e.uf       = m_uf;
    e.tready   = (m_fifo.size() != DEPTH);
    e.ecnt     = 16'(m_ecnt);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cycle_body();
    end
  endtask

  // Asynchronous reset between edges, 3 clocks long, release on a falling edge.
  task automatic do_reset();
    tvalid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tready", tready, 0);
    check("rst_video_on", video_on, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb_out, 0);
    check("rst_locked", locked, 0);
    check("rst_underflow", underflow, 0);
    check("rst_sync_err", sync_err, 0);
`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_fifo.delete();
    exp_q.delete();
    cyc = 0; m_ecnt = 0; m_locked = 0; m_uf = 0;
    n_serr_seen = 0; saw_low = 0;
    cycle_body();
  endtask

  // Monitor: compare every post-edge output against the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        check("sb_has_entry", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("video_on", video_on, e.video_on);
        check("pixel_x", pixel_x, e.x);
        check("pixel_y", pixel_y, e.y);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("rgb_out", rgb_out, e.rgb);
        check("locked", locked, e.locked);
        check("sync_err", sync_err, e.serr);
        check("underflow", underflow, e.uf);
        check("tready", tready, e.tready);
`ifdef AXIS_VIDEO_SINK_ERR_CNT_EN
        check("err_count", err_count, e.ecnt);
`endif
      end
      if (sync_err) n_serr_seen++;
      if (!tready)  saw_low = 1;
    end
  end

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    cyc = 0; m_ecnt = 0; m_locked = 0; m_uf = 0;
    n_serr_seen = 0; saw_low = 0;
    valid_pct = 100; stall_lo = -1; stall_hi = -1;

    // Continuous clean frames of a constant colour; FIFO fills in blanking.
    src_q.delete();
    repeat (5) gen_frame(1, -1, -1, 0);
    do_reset();
    run(4 * FRAME);
    check("A_sync_err_pulses", n_serr_seen, 0);
    check("A_tready_fell", saw_low, 1);

    // Mid-frame start: 100 non-SOF beats precede the first frame.
    src_q.delete();
    for (int i = 0; i < 100; i++) src_q.push_back({1'b0, 1'b0, 24'($urandom)});
    repeat (3) gen_frame(0, -1, -1, 0);
    do_reset();
    run(3 * FRAME);
    check("B_sync_err_pulses", n_serr_seen, 0);

    // 40-cycle source stall during line 3 of the first locked frame.
    src_q.delete();
    repeat (5) gen_frame(0, -1, -1, 0);
    stall_lo = FRAME + 3 * HT + 2;
    stall_hi = stall_lo + 40;
    do_reset();
    run(4 * FRAME);
    check("C_sync_err_pulses", n_serr_seen, 1);
    stall_lo = -1; stall_hi = -1;

    // Early tlast at column HR-2 of line 5.
    src_q.delete();
    gen_frame(0, 5, HR - 2, 0);
    repeat (2) gen_frame(0, -1, -1, 0);
    do_reset();
    run(3 * FRAME);
    check("D_sync_err_pulses", n_serr_seen, 1);

    // Random valid gaps and sporadic framing errors, ending mid-line.
    src_q.delete();
    valid_pct = 85;
    repeat (7) gen_frame(0, -1, -1, 1);
    do_reset();
    run(5 * FRAME + 5 * HT + 7);

    // Reset mid-line discards buffered beats; clean frames follow.
    src_q.delete();
    valid_pct = 100;
    repeat (3) gen_frame(0, -1, -1, 0);
    do_reset();
    run(3 * FRAME);
    check("F_sync_err_pulses", n_serr_seen, 0);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_video_sink.md
AXIS_VIDEO_SINK -- requirements
Module: axis_video_sink

Interface
REQ-001 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, a power of two from 4 to 64.
REQ-006 SHALL have these ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-low
- tdata  input  24  RGB888 {r,g,b}
- tvalid  input  1  beat valid
- tuser  input  1  start of frame
- tlast  input  1  end of line
- tready  output  1  sink ready
- video_on  output  1  active region
- pixel_x  output  10  active column
- pixel_y  output  10  active row
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- rgb_out  output  12  RGB444
- locked  output  1  stream aligned to timing
- underflow  output  1  sticky FIFO underflow
- sync_err  output  1  one-cycle framing error pulse

Function
REQ-007 SHALL run free-running counters h_cnt over 0..H_RES+H_FP+H_SYNC+H_BP-1 (800) and v_cnt over 0..V_RES+V_FP+V_SYNC+V_BP-1 (525); v_cnt SHALL advance when h_cnt wraps.
REQ-008 Active region SHALL be h_cnt<H_RES and v_cnt<V_RES; sync SHALL be low for h_cnt in [H_RES+H_FP, H_RES+H_FP+H_SYNC), with vsync defined the same way from v_cnt.
REQ-009 SHALL buffer {tuser,tlast,tdata} in a show-ahead FIFO of FIFO_DEPTH entries; a beat SHALL be written when tvalid&&tready.
REQ-010 tready SHALL be !full; tready SHALL NOT depend combinationally on tvalid, and a pop while full SHALL NOT accept a write in the same cycle.
REQ-011 SHALL implement state SEARCH (locked=0) and state LOCKED (locked=1).
REQ-012 In SEARCH, a head entry with tuser=0 SHALL be popped and discarded, one per cycle.
REQ-013 In SEARCH, a head entry with tuser=1 SHALL be held until h_cnt=0 and v_cnt=0; it SHALL then be popped and displayed, and the state SHALL become LOCKED.
REQ-014 In LOCKED, exactly one entry SHALL be popped on each active-region cycle, and none outside it.
REQ-015 In LOCKED, if the FIFO is empty on an active cycle, the block SHALL output black, set underflow, pulse sync_err and go to SEARCH.
REQ-016 In LOCKED, any of the following popped entries SHALL pulse sync_err and send the state to SEARCH; the pixel itself SHALL still be displayed:
- tuser=1 at a position other than (0,0)
- tlast=1 at h_cnt≠H_RES-1
- tlast=0 at h_cnt=H_RES-1
REQ-017 rgb_out SHALL be {tdata[23:20],tdata[15:12],tdata[7:4]} of the displayed entry, and 0 outside the active region or while in SEARCH.
REQ-018 All video outputs SHALL be registered with a latency of exactly 1 clk from the counter values, all mutually aligned; pixel_x/pixel_y SHALL be h_cnt/v_cnt when active and 0 otherwise.
REQ-019 underflow SHALL stay set until reset.

Reset
REQ-020 Assertion of reset (low) SHALL asynchronously clear the following; deassertion SHALL be used synchronously:
- counters and FIFO pointers (FIFO empty)
- state to SEARCH
- outputs: tready=0, video_on=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, rgb_out=0, locked=0, underflow=0, sync_err=0
REQ-021 tready SHALL go to 1 on the first clk edge after reset deasserts; a reset mid-frame SHALL discard all buffered beats.

Configuration
REQ-022 With macro AXIS_VIDEO_SINK_ERR_CNT_EN defined, the block SHALL add output err_count[15:0], reset to 0, which increments on each sync_err pulse and saturates at 16'hFFFF.
REQ-023 Without AXIS_VIDEO_SINK_ERR_CNT_EN, the err_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Reset, then stream continuous correct frames of 640x480 with tdata=24'hF0A05A -> locked=1 from frame 1, rgb_out=12'hFA5 on active pixels, no sync_err, hsync low 96 clks per 800-clk line.
REQ-025 Stream starting mid-frame with 100 beats of tuser=0, then a tuser=1 beat -> 100 beats dropped, lock at next (0,0), first displayed pixel is the tuser=1 beat.
REQ-026 Stall tvalid for 40 clks during line 10 in LOCKED -> underflow=1, sync_err one pulse, locked=0, black output, relock at next frame start.
REQ-027 tlast asserted at column 638 of line 5 -> sync_err pulse with video_on, SEARCH entered; with macro defined, err_count=1.
REQ-028 tvalid=1 held while timing is in blanking -> tready falls after FIFO_DEPTH accepted beats, with no overflow or data loss.
REQ-029 Assert reset for 3 clks mid-line 200 -> all outputs at reset values immediately, FIFO empty, tready=1 one edge after release.
